acc_reg_n: RTL and testbench

- Parametrised successor to the single-bit accumulator slice: a WIDTH-bit accumulator register.
- Write sources: direct load from ain, or capture from the shared open-drain data bus.
- Adds a multi-cycle shift/rotate engine with carry-out and zero flags.
- Sits between the ALU (consumes aout, cout, zero) and the data bus (read-back via open-drain pull-downs).

---
 rtl/acc_reg_n.sv | 100 ++++++++++
 tb/tb_acc_reg_n.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_reg_n.sv
// rtl/acc_reg_n.sv - WIDTH-bit accumulator register with open-drain bus read-back and shift/rotate engine
module acc_reg_n #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             wra,
   input  logic             ldb,
   input  logic             rda,
   input  logic [WIDTH-1:0] ain,
   output logic [WIDTH-1:0] aout,
   inout  wire  [WIDTH-1:0] dbus,
   input  logic             sh_start,
   input  logic             sh_dir,
   input  logic             sh_rot,
   input  logic [CW-1:0]    sh_cnt,
   input  logic             sin,
   output logic             busy,
   output logic             done,
   output logic             cout,
   output logic             zero
);

   localparam logic [CW-1:0] CMAX = CW'(WIDTH);

   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             dir_q;
   logic             rot_q;
   logic             sin_q;
   logic             busy_r;
   logic             done_r;
   logic             cout_r;

   logic [CW-1:0]    n_eff;
   logic             sh_out;
   logic             fill;
   logic [WIDTH-1:0] sh_val;

   // Shift counts beyond the register width are clamped to one full pass.
   assign n_eff = (sh_cnt > CMAX) ? CMAX : sh_cnt;

   always_comb begin
      sh_out = dir_q ? acc[0] : acc[WIDTH-1];
      fill   = rot_q ? sh_out : sin_q;
      sh_val = dir_q ? {fill, acc[WIDTH-1:1]} : {acc[WIDTH-2:0], fill};
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         acc    <= '0;
         cnt    <= '0;
         dir_q  <= 1'b0;
         rot_q  <= 1'b0;
         sin_q  <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         cout_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (busy_r) begin
            // Loads and new starts are dropped while a sequence is running.
            acc    <= sh_val;
            cout_r <= sh_out;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end
         end else if (wra) begin
            acc <= ain;
         end else if (ldb) begin
            acc <= dbus;
         end else if (sh_start) begin
            dir_q <= sh_dir;
            rot_q <= sh_rot;
            sin_q <= sin;
            cnt   <= n_eff;
            if (n_eff == '0) begin
               done_r <= 1'b1;
            end else begin
               busy_r <= 1'b1;
            end
         end
      end
   end

   // Open-drain read-back: only zeros are driven, ones come from the bus pull-ups.
   for (genvar i = 0; i < WIDTH; i++) begin : g_od
      assign dbus[i] = (rda && !acc[i]) ? 1'b0 : 1'bz;
   end

   assign aout = acc;
   assign busy = busy_r;
   assign done = done_r;
   assign cout = cout_r;
   assign zero = (acc == '0);

endmodule

// File: tb/tb_acc_reg_n.sv
// tb/tb_acc_reg_n.sv - self-checking bench for acc_reg_n against a queue-based reference model
module tb_acc_reg_n;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          clk      = 1'b0;
   logic          nrst     = 1'b1;
   logic          wra      = 1'b0;
   logic          ldb      = 1'b0;
   logic          rda      = 1'b0;
   logic          sh_start = 1'b0;
   logic          sh_dir   = 1'b0;
   logic          sh_rot   = 1'b0;
   logic          sin      = 1'b0;
   logic [W-1:0]  ain      = '0;
   logic [CW-1:0] sh_cnt   = '0;
   logic          ext_en   = 1'b0;
   logic [W-1:0]  ext_val  = '1;

   wire  [W-1:0]  dbus;
   logic [W-1:0]  aout;
   logic          busy;
   logic          done;
   logic          cout;
   logic          zero;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   acc_reg_n #(.WIDTH(W), .CW(CW)) dut (
      .clk(clk), .nrst(nrst), .wra(wra), .ldb(ldb), .rda(rda),
      .ain(ain), .aout(aout), .dbus(dbus),
      .sh_start(sh_start), .sh_dir(sh_dir), .sh_rot(sh_rot),
      .sh_cnt(sh_cnt), .sin(sin),
      .busy(busy), .done(done), .cout(cout), .zero(zero)
   );

   // Bus pull-ups plus an external open-drain talker.
   for (genvar i = 0; i < W; i++) begin : g_bus
      pullup pu (dbus[i]);
      assign dbus[i] = (ext_en && !ext_val[i]) ? 1'b0 : 1'bz;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a start precomputes every intermediate value into a queue.
   int m_acc;
   int m_cout;
   int m_done;
   int q_acc[$];
   int q_cout[$];

   function automatic int bus_exp();
      int b;
      b = 255;
      if (rda)    b = b & m_acc;
      if (ext_en) b = b & int'(ext_val);
      return b;
   endfunction

   task automatic model_reset();
      m_acc  = 0;
      m_cout = 0;
      m_done = 0;
      q_acc.delete();
      q_cout.delete();
   endtask

   task automatic model_step();
      int n, v, c, f;
      if (!nrst) begin
         model_reset();
         return;
      end
      m_done = 0;
      if (q_acc.size() > 0) begin
         m_acc  = q_acc.pop_front();
         m_cout = q_cout.pop_front();
         if (q_acc.size() == 0) m_done = 1;
      end else if (wra) begin
         m_acc = int'(ain);
      end else if (ldb) begin
         m_acc = bus_exp();
      end else if (sh_start) begin
         n = (int'(sh_cnt) > W) ? W : int'(sh_cnt);
         if (n == 0) m_done = 1;
         v = m_acc;
         for (int k = 0; k < n; k++) begin
            if (sh_dir) begin
               c = v % 2;
               f = sh_rot ? c : int'(sin);
               v = v / 2 + f * 128;
            end else begin
               c = v / 128;
               f = sh_rot ? c : int'(sin);
               v = (v * 2) % 256 + f;
            end
            q_acc.push_back(v);
            q_cout.push_back(c);
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         if (!nrst) model_reset();
         chk("aout", aout, m_acc);
         chk("cout", cout, m_cout);
         chk("busy", busy, q_acc.size() > 0);
         chk("done", done, m_done);
         chk("zero", zero, m_acc == 0);
         chk("dbus", dbus, bus_exp());
      end
   end

   task automatic cyc(input int k = 1);
      repeat (k) begin
         @(posedge clk);
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      int lv[3];
      int lc[3];
      lv = '{8'h02, 8'h04, 8'h08};
      lc = '{1, 0, 0};

      #1 nrst = 1'b0;
      ain = 8'hA5;
      wra = 1'b1;
      cyc();
      chk("rst_aout", aout, 0);
      chk("rst_zero", zero, 1);
      chk("rst_busy", busy, 0);
      nrst = 1'b1;
      cyc();
      chk("wra_aout", aout, 8'hA5);
      chk("wra_zero", zero, 0);
      chk("wra_cout", cout, 0);

      ain = 8'h3C;
      cyc();
      wra = 1'b0;
      rda = 1'b1;
      #1 chk("rd_bus", dbus, 8'h3C);
      rda = 1'b0;
      #1 chk("rd_z", dbus, 8'hFF);
      ext_en  = 1'b1;
      ext_val = 8'h81;
      ldb     = 1'b1;
      cyc();
      ldb    = 1'b0;
      ext_en = 1'b0;
      chk("ldb_aout", aout, 8'h81);

      sh_start = 1'b1; sh_dir = 1'b0; sh_rot = 1'b0; sin = 1'b0; sh_cnt = 4'd3;
      cyc();
      sh_start = 1'b0;
      chk("shl_start_busy", busy, 1);
      chk("shl_start_aout", aout, 8'h81);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("shl_aout", aout, lv[k]);
         chk("shl_cout", cout, lc[k]);
         chk("shl_done", done, k == 2);
      end
      cyc();
      chk("shl_done_off", done, 0);

      ain = 8'h81; wra = 1'b1;
      cyc();
      wra = 1'b0;
      for (int r = 0; r < 2; r++) begin
         sh_start = 1'b1; sh_dir = 1'b1; sh_rot = 1'b1; sh_cnt = (r == 0) ? 4'd8 : 4'd15;
         cyc();
         sh_start = 1'b0;
         cyc(8);
         chk("rot_aout", aout, 8'h81);
         chk("rot_cout", cout, 1);
         chk("rot_done", done, 1);
         cyc();
         chk("rot_done_off", done, 0);
      end

      sh_start = 1'b1; sh_dir = 1'b0; sh_rot = 1'b0; sin = 1'b0; sh_cnt = 4'd3;
      cyc();
      ain = 8'hFF; wra = 1'b1; sh_dir = 1'b1; sin = 1'b1;
      cyc(3);
      chk("ilk_aout", aout, 8'h08);
      chk("ilk_done", done, 1);
      wra = 1'b0; sh_start = 1'b0;

      sh_start = 1'b1; sh_cnt = 4'd0;
      cyc();
      sh_start = 1'b0;
      chk("n0_busy", busy, 0);
      chk("n0_done", done, 1);
      chk("n0_aout", aout, 8'h08);
      cyc();
      chk("n0_done_off", done, 0);

      sh_start = 1'b1; sh_dir = 1'b0; sh_rot = 1'b0; sin = 1'b0; sh_cnt = 4'd5;
      cyc();
      sh_start = 1'b0;
      cyc();
      nrst = 1'b0;
      #1;
      chk("abort_aout", aout, 0);
      chk("abort_busy", busy, 0);
      cyc();
      nrst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk("abort_no_done", done, 0);
      end
      ain = 8'h81; wra = 1'b1;
      cyc();
      wra = 1'b0;
      sh_start = 1'b1; sh_dir = 1'b1; sh_rot = 1'b0; sin = 1'b1; sh_cnt = 4'd2;
      cyc();
      sh_start = 1'b0;
      cyc(2);
      chk("post_abort_aout", aout, 8'hE0);
      chk("post_abort_done", done, 1);

      for (int i = 0; i < 800; i++) begin
         wra      = ($urandom % 8) == 0;
         ldb      = ($urandom % 8) == 0;
         rda      = $urandom % 2;
         sh_start = ($urandom % 3) == 0;
         sh_dir   = $urandom % 2;
         sh_rot   = $urandom % 2;
         sin      = $urandom % 2;
         sh_cnt   = CW'($urandom % 16);
         ain      = W'($urandom);
         ext_en   = $urandom % 2;
         ext_val  = W'($urandom);
         nrst     = ($urandom % 64) != 0;
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
